// File: rtl/coef_loader_pkg.sv
// Shared constants, command codes and FSM state encoding for the coefficient loader.
package coef_loader_pkg;

  localparam int ADDR_W         = 14;
  localparam int DATA_W         = 36;
  localparam int BYTES_PER_WORD = 5;

  localparam logic [7:0] CMD_WR_L = 8'h01;
  localparam logic [7:0] CMD_WR_R = 8'h02;
  localparam logic [7:0] CMD_RD_L = 8'h03;
  localparam logic [7:0] CMD_RD_R = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WR_COL,
    ST_WR_STB,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_SEND
  } state_e;

  function automatic logic is_valid_cmd(input logic [7:0] b);
    return (b == CMD_WR_L) || (b == CMD_WR_R) || (b == CMD_RD_L) || (b == CMD_RD_R);
  endfunction

endpackage

// File: rtl/coef_word_shifter.sv
// 40-bit byte shift register: assembles payload bytes MSB first on write and
// serialises a zero-extended coefficient MSB first on read.
module coef_word_shifter
  import coef_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              shift_in_i,
  input  logic [7:0]        byte_i,
  input  logic              shift_out_i,
  output logic [DATA_W-1:0] next_word_o,
  output logic [7:0]        byte_o,
  output logic              last_o
);

  localparam int SR_W = 8 * BYTES_PER_WORD;

  logic [SR_W-1:0] sr_q, sr_d;
  logic [2:0]      cnt_q, cnt_d;

  // Word as it will stand once byte_i is shifted in; bits above DATA_W are dropped.
  assign next_word_o = {sr_q[DATA_W-9:0], byte_i};
  assign byte_o      = sr_q[SR_W-1:SR_W-8];
  assign last_o      = (cnt_q == 3'(BYTES_PER_WORD - 1));

  // Next-state: parallel load wins, otherwise shift one byte and count it.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = {{(SR_W-DATA_W){1'b0}}, load_data_i};
      cnt_d = '0;
    end else if (shift_in_i) begin
      sr_d  = {sr_q[SR_W-9:0], byte_i};
      cnt_d = last_o ? 3'd0 : cnt_q + 3'd1;
    end else if (shift_out_i) begin
      sr_d  = {sr_q[SR_W-9:0], 8'h00};
      cnt_d = last_o ? 3'd0 : cnt_q + 3'd1;
    end
  end

  // Shift register and byte counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/coef_loader.sv
// Byte-stream loader/readback engine for the stereo coefficient RAM.
// Handshakes: a byte moves on rx (tx) when valid && ready are both high at a
// rising clock edge; tx_data/tx_valid are held unchanged while not accepted.
module coef_loader
  import coef_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] addrLrw,
  output logic [ADDR_W-1:0] addrRrw,
  output logic [DATA_W-1:0] datainLrw,
  output logic [DATA_W-1:0] datainRrw,
  output logic              weL,
  output logic              weR,
  input  logic [DATA_W-1:0] dataoutLrw,
  input  logic [DATA_W-1:0] dataoutRrw,
  output logic              busy,
  output logic              cmd_err
);

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic              is_right_q, is_right_d;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_l_q, addr_l_d, addr_r_q, addr_r_d;
  logic [DATA_W-1:0] din_l_q, din_l_d, din_r_q, din_r_d;
  logic              cmd_err_q, cmd_err_d;
  logic              tx_valid_q, tx_valid_d;

  logic              rx_fire, tx_fire;
  logic              bus_addr_en, din_en;
  logic [ADDR_W-1:0] bus_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              sh_load, sh_in, sh_out, sh_last;
  logic [DATA_W-1:0] sh_next_word, sh_load_data;
  logic [7:0]        sh_byte;

  assign rx_ready     = !reset && ((state_q == ST_IDLE) || (state_q == ST_HDR) || (state_q == ST_WR_COL));
  assign rx_fire      = rx_valid && rx_ready;
  assign tx_fire      = tx_valid_q && tx_ready;
  assign addr_inc     = addr_q + 1'b1;
  assign sh_load_data = is_right_q ? dataoutRrw : dataoutLrw;

  assign tx_data   = sh_byte;
  assign tx_valid  = tx_valid_q;
  assign addrLrw   = addr_l_q;
  assign addrRrw   = addr_r_q;
  assign datainLrw = din_l_q;
  assign datainRrw = din_r_q;
  assign weL       = (state_q == ST_WR_STB) && !is_right_q;
  assign weR       = (state_q == ST_WR_STB) && is_right_q;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_err   = cmd_err_q;

  coef_word_shifter u_shifter (
    .clk_i       (clock),
    .rst_i       (reset),
    .load_i      (sh_load),
    .load_data_i (sh_load_data),
    .shift_in_i  (sh_in),
    .byte_i      (rx_data),
    .shift_out_i (sh_out),
    .next_word_o (sh_next_word),
    .byte_o      (sh_byte),
    .last_o      (sh_last)
  );

  // Command FSM next-state and RAM bus updates; only the selected channel's bus moves.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    is_right_d  = is_right_q;
    hdr_cnt_d   = hdr_cnt_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    addr_l_d    = addr_l_q;
    addr_r_d    = addr_r_q;
    din_l_d     = din_l_q;
    din_r_d     = din_r_q;
    cmd_err_d   = 1'b0;
    sh_load     = 1'b0;
    sh_in       = 1'b0;
    sh_out      = 1'b0;
    bus_addr_en = 1'b0;
    din_en      = 1'b0;
    bus_addr    = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (is_valid_cmd(rx_data)) begin
            is_wr_d    = (rx_data == CMD_WR_L) || (rx_data == CMD_WR_R);
            is_right_d = (rx_data == CMD_WR_R) || (rx_data == CMD_RD_R);
            hdr_cnt_d  = 2'd0;
            state_d    = ST_HDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (rx_fire) begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd0: addr_d = {rx_data[ADDR_W-9:0], addr_q[7:0]};
            2'd1: addr_d = {addr_q[ADDR_W-1:8], rx_data};
            2'd2: cnt_d  = {rx_data[ADDR_W-9:0], cnt_q[7:0]};
            default: begin
              cnt_d = {cnt_q[ADDR_W-1:8], rx_data};
              if (is_wr_q) begin
                state_d = ST_WR_COL;
              end else begin
                bus_addr_en = 1'b1;
                state_d     = ST_RD_ADDR;
              end
            end
          endcase
        end
      end
      ST_WR_COL: begin
        if (rx_fire) begin
          sh_in = 1'b1;
          if (sh_last) begin
            bus_addr_en = 1'b1;
            din_en      = 1'b1;
            state_d     = ST_WR_STB;
          end
        end
      end
      ST_WR_STB: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          addr_d  = addr_inc;
          cnt_d   = cnt_q - 1'b1;
          state_d = ST_WR_COL;
        end
      end
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        sh_load = 1'b1;
        state_d = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (tx_fire) begin
          sh_out = 1'b1;
          if (sh_last) begin
            if (cnt_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              addr_d      = addr_inc;
              cnt_d       = cnt_q - 1'b1;
              bus_addr    = addr_inc;
              bus_addr_en = 1'b1;
              state_d     = ST_RD_ADDR;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus_addr_en) begin
      if (is_right_q) addr_r_d = bus_addr;
      else            addr_l_d = bus_addr;
    end
    if (din_en) begin
      if (is_right_q) din_r_d = sh_next_word;
      else            din_l_d = sh_next_word;
    end
  end

  assign tx_valid_d = (state_d == ST_RD_SEND);

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      is_right_q <= 1'b0;
      hdr_cnt_q  <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      addr_l_q   <= '0;
      addr_r_q   <= '0;
      din_l_q    <= '0;
      din_r_q    <= '0;
      cmd_err_q  <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      is_right_q <= is_right_d;
      hdr_cnt_q  <= hdr_cnt_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      addr_l_q   <= addr_l_d;
      addr_r_q   <= addr_r_d;
      din_l_q    <= din_l_d;
      din_r_q    <= din_r_d;
      cmd_err_q  <= cmd_err_d;
      tx_valid_q <= tx_valid_d;
    end
  end

endmodule
